seven_segment_reader: RTL
=========================

# seven_segment_reader

Observes a multiplexed, active-low common-anode 7-segment display bus (segment lines plus per-digit anode enables) and recovers the displayed hex/BCD digits. It is the inverse of our 4-bit-to-segment decoder path and sits on the board-test and loopback side of the display subsystem. It filters scan glitches, converts each stable digit pattern back to a 4-bit code, and assembles one frame per full scan. Completed frames are offered downstream on a valid/ready handshake.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (2..8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted (≥2).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg_in` in 7: segment lines, active-low; bit0=a (top), clockwise through bit5=f, bit6=g (middle).
- `an_in` in DIGITS: digit enables, active-low, one-hot when valid.
- `frame_valid` out 1: a frame is held in the output buffer.
- `frame_ready` in 1: downstream accepts the frame.
- `frame_data` out 4*DIGITS: digit i code in bits [4i+3:4i].
- `frame_err` out DIGITS: bit i is set when digit i had an unrecognised pattern.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Reset values: `frame_valid`=0, `frame_data`=0, `frame_err`=0, `overrun`=0. Seen-mask, stability counter and slots are cleared.
- Stability filter:
  - The sampled pair {an, seg} is compared with the previous sample each cycle.
  - If it is equal, the counter increments, saturating at STABLE_CYCLES. If it differs, the counter resets to 1.
  - When the counter reaches STABLE_CYCLES and `an` is exactly one-hot-low, fire a single capture strobe. No re-capture occurs until the pair changes.
  - An `an` value that is all-high or has multiple lows is never captured.
- Pattern to code:
  - Patterns 0..9 map to 0x0..0x9, using the inverse of the decoder table (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
  - 1111111 (blank) maps to 0xF with no error.
  - Any other pattern maps to 0xE and sets that digit's error bit.
- Capture writes the code and error bit into slot i and sets seen[i]. Recapturing an already-seen digit overwrites the slot.
- Frame completion when seen is all ones:
  - If the output buffer is free, or is being emptied this cycle (`frame_valid & frame_ready`), load `frame_data`/`frame_err`, set `frame_valid`, and clear seen.
  - Otherwise drop the frame, pulse `overrun`, clear seen, and leave `frame_data` unchanged.
- Handshake:
  - `frame_valid` stays high and `frame_data` stays stable until `frame_ready` is sampled high.
  - `frame_valid` drops the cycle after acceptance unless a new frame loads in the same cycle.
- Asserting `rst_n` mid-frame discards partial slots. A fresh full scan is required after release.

## Timing
- Input synchronisation adds 2 cycles (see Configuration).
- Capture occurs STABLE_CYCLES−1 edges after the first synchronised sample of a new pair. The slot is written on the following edge.
- `frame_valid` rises on the edge after the last slot write.
- `overrun` is high for exactly one cycle.
- `frame_ready` is a registered-path input only. There is no combinational path from `frame_ready` to `frame_valid`.

## Configuration
- `SEG_READER_SYNC_EN` defined: `seg_in` and `an_in` each pass through a 2-flop synchroniser, adding 2 cycles of latency.
- `SEG_READER_SYNC_EN` undefined: inputs feed the stability filter directly. Use this only when the display bus is generated in `clk`'s domain.

## Structure
- Shared package `seven_seg_pkg` holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - codes CODE_BLANK=4'hF and CODE_ERR=4'hE;
  - the bit-order definition for a..g.
- The decoder and this block both use the same constants.
- Sub-module `seven_segment_encoder`: a combinational 7-bit pattern to {err, code[3:0]} lookup. It is instantiated once.

## Test plan
- Reset, then idle bus (`an_in`=all ones) for 50 cycles -> `frame_valid`=0, `frame_data`=0, `overrun` never asserted.
- DIGITS=4, STABLE_CYCLES=4, each digit held 8 cycles: digit0=0010010, digit1=0100100, digit2=1000000, digit3=0100100 -> one frame, `frame_data`=16'h2025, `frame_err`=4'b0000.
- Pattern for digit1 held only 3 cycles, then `an_in` changes -> no capture for digit1 and no frame until digit1 is held ≥4 cycles.
- digit1=0101010 and digit3=1111111 -> `frame_data`[7:4]=0xE, [15:12]=0xF, `frame_err`=4'b0010.
- `frame_ready`=0 through a second full scan -> `overrun` pulses for 1 cycle and `frame_data` keeps the first frame. Then `frame_ready`=1 for 1 cycle -> `frame_valid` falls next cycle.
- Capture digits 0 and 1, pulse `rst_n` low for 2 cycles, then scan only digits 2 and 3 -> no frame. After digits 0 and 1 are rescanned -> frame emitted.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment bit order, active-low digit patterns
// and the special codes used by both the decoder and the reader.
`timescale 1ns/1ps
package seven_seg_pkg;

    // Segment bit positions within the 7-bit bus (a at the top, clockwise, g in the middle).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low patterns, written g..a from MSB to LSB.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef struct packed {
        logic       err;
        logic [3:0] code;
    } seg_code_t;

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational lookup from an active-low segment pattern back to its 4-bit code;
// unrecognised patterns yield CODE_ERR with the error flag set.
`timescale 1ns/1ps
module seven_segment_encoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output seg_code_t  code_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives code_o and no latch is inferred.
        code_o.err  = 1'b0;
        code_o.code = CODE_ERR;
        case (seg_i)
            SEG_0:     code_o.code = 4'h0;
            SEG_1:     code_o.code = 4'h1;
            SEG_2:     code_o.code = 4'h2;
            SEG_3:     code_o.code = 4'h3;
            SEG_4:     code_o.code = 4'h4;
            SEG_5:     code_o.code = 4'h5;
            SEG_6:     code_o.code = 4'h6;
            SEG_7:     code_o.code = 4'h7;
            SEG_8:     code_o.code = 4'h8;
            SEG_9:     code_o.code = 4'h9;
            SEG_BLANK: code_o.code = CODE_BLANK;
            default:   code_o.err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers digit codes from a multiplexed active-low 7-segment bus and emits one frame
// per full scan on valid/ready. Define SEG_READER_SYNC_EN to add 2-flop input synchronisers.
`timescale 1ns/1ps
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   frame_data,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  overrun
);

    localparam int              CW         = $clog2(STABLE_CYCLES + 1);
    localparam int              IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int              PW         = DIGITS + 7;
    localparam logic [CW-1:0]   STABLE_CNT = CW'(STABLE_CYCLES);

    logic [6:0]        seg_s;
    logic [DIGITS-1:0] an_s;

`ifdef SEG_READER_SYNC_EN
    logic [6:0]        seg_meta_q, seg_sync_q;
    logic [DIGITS-1:0] an_meta_q,  an_sync_q;

    // Synchronisers idle at the blank/all-off bus value so reset never looks like a digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= '1;
            seg_sync_q <= '1;
            an_meta_q  <= '1;
            an_sync_q  <= '1;
        end else begin
            seg_meta_q <= seg_in;
            seg_sync_q <= seg_meta_q;
            an_meta_q  <= an_in;
            an_sync_q  <= an_meta_q;
        end
    end

    assign seg_s = seg_sync_q;
    assign an_s  = an_sync_q;
`else
    assign seg_s = seg_in;
    assign an_s  = an_in;
`endif

    logic [PW-1:0] pair_s, pair_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          one_cold, multi_low;
    logic [IW-1:0] idx_s, cap_idx_q;
    logic          cap_d, cap_q;

    assign pair_s = {an_s, seg_s};

    always_comb begin
        one_cold  = 1'b0;
        multi_low = 1'b0;
        idx_s     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) begin
                if (one_cold) multi_low = 1'b1;
                one_cold = 1'b1;
                idx_s    = IW'(i);
            end
        end
        one_cold = one_cold & ~multi_low;
    end

    // Strobe once on the transition into saturation; a held pair never re-fires.
    always_comb begin
        if (pair_s == pair_q) begin
            cnt_d = (cnt_q == STABLE_CNT) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = CW'(1);
        end
        cap_d = one_cold && (cnt_d == STABLE_CNT) && (cnt_q != STABLE_CNT);
    end

    seg_code_t enc_code;

    // pair_q still holds the captured pattern during the strobe cycle.
    seven_segment_encoder u_encoder (
        .seg_i  (pair_q[6:0]),
        .code_o (enc_code)
    );

    logic [4*DIGITS-1:0] slot_data_q, slot_data_d;
    logic [DIGITS-1:0]   slot_err_q,  slot_err_d;
    logic [DIGITS-1:0]   seen_q,      seen_d;
    logic                frame_done, buf_free, load, drop;
    logic                valid_q, valid_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                overrun_q;

    assign frame_done = &seen_q;
    assign buf_free   = !valid_q || frame_ready;
    assign load       = frame_done && buf_free;
    assign drop       = frame_done && !buf_free;

    always_comb begin
        seen_d      = frame_done ? '0 : seen_q;
        slot_data_d = slot_data_q;
        slot_err_d  = slot_err_q;
        if (cap_q) begin
            seen_d[cap_idx_q]                    = 1'b1;
            slot_data_d[{cap_idx_q, 2'b00} +: 4] = enc_code.code;
            slot_err_d[cap_idx_q]                = enc_code.err;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = slot_data_q;
            err_d   = slot_err_q;
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q      <= '1;
            cnt_q       <= '0;
            cap_q       <= 1'b0;
            cap_idx_q   <= '0;
            // NOTE: slots are plain flops, not a RAM, so clearing them on reset is cheap and keeps partial frames out.
            slot_data_q <= '0;
            slot_err_q  <= '0;
            seen_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pair_q      <= pair_s;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            cap_idx_q   <= idx_s;
            slot_data_q <= slot_data_d;
            slot_err_q  <= slot_err_d;
            seen_q      <= seen_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            overrun_q   <= drop;
        end
    end

    assign frame_valid = valid_q;
    assign frame_data  = data_q;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;

endmodule
